// File: rtl/wb_load_packer.sv
// Packs pairs of 32-bit Wishbone stream words into 64-bit load messages
// (first word in the low half) and buffers them in a small FIFO.
module wb_load_packer #(
   parameter  int unsigned DEPTH = 2,
   localparam int unsigned CNT_W = $clog2(DEPTH) + 1
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [31:0]      word_recv_msg,
   input  logic             word_recv_val,
   output logic             word_recv_rdy,
   input  logic             flush,
   output logic [63:0]      load_send_msg,
   output logic             load_send_val,
   input  logic             load_send_rdy,
   output logic             partial,
   output logic [CNT_W-1:0] count
);

   localparam int unsigned WORD_W = 32;
   localparam int unsigned MSG_W  = 64;
   localparam int unsigned PTR_W  = $clog2(DEPTH);

   logic              active;
   logic [WORD_W-1:0] hold_lo;
   logic [PTR_W-1:0]  wr_ptr;
   logic [PTR_W-1:0]  rd_ptr;
   logic [MSG_W-1:0]  mem [DEPTH];
   logic              word_fire;
   logic              push;
   logic              pop;

   // A second word needs FIFO room now; a same-cycle pop does not count.
   assign word_recv_rdy = active && !flush && (!partial || (count < CNT_W'(DEPTH)));
   assign word_fire     = word_recv_val && word_recv_rdy;
   assign push          = word_fire && partial;
   assign pop           = load_send_val && load_send_rdy;
   assign load_send_val = (count != '0);
   assign load_send_msg = mem[rd_ptr];

   // Control state: active flag, half-word flag, pointers, occupancy.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         active  <= 1'b0;
         partial <= 1'b0;
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         count   <= '0;
      end else begin
         active <= 1'b1;
         if (flush) begin
            partial <= 1'b0;
         end else if (word_fire) begin
            partial <= !partial;
         end
         if (push) begin
            wr_ptr <= wr_ptr + PTR_W'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + PTR_W'(1);
         end
         case ({push, pop})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end

   // Datapath storage is intentionally not reset.
   always_ff @(posedge clk) begin
      if (word_fire && !partial) begin
         hold_lo <= word_recv_msg;
      end
      if (push) begin
         mem[wr_ptr] <= {word_recv_msg, hold_lo};
      end
   end

endmodule

// File: tb/tb_wb_load_packer.sv
// Directed, table-driven bench for wb_load_packer (DEPTH=2).
module tb_wb_load_packer;

   localparam int unsigned DEPTH = 2;
   localparam int unsigned CNT_W = $clog2(DEPTH) + 1;
   localparam int unsigned NV    = 21;

   logic             clk = 1'b0;
   logic             reset_n = 1'b0;
   logic [31:0]      word_recv_msg = '0;
   logic             word_recv_val = 1'b0;
   logic             word_recv_rdy;
   logic             flush = 1'b0;
   logic [63:0]      load_send_msg;
   logic             load_send_val;
   logic             load_send_rdy = 1'b0;
   logic             partial;
   logic [CNT_W-1:0] count;

   int vectors = 0;
   int miscompares = 0;

   typedef struct {
      logic [31:0]      w;
      logic             wv;
      logic             fl;
      logic             lr;
      logic             e_rdy;
      logic             e_val;
      logic             e_part;
      logic [CNT_W-1:0] e_cnt;
      logic [63:0]      e_msg;
   } vec_t;

   vec_t vecs [NV];
   logic [63:0] q [$];

   wb_load_packer #(.DEPTH(DEPTH)) dut (
      .clk           (clk),
      .reset_n       (reset_n),
      .word_recv_msg (word_recv_msg),
      .word_recv_val (word_recv_val),
      .word_recv_rdy (word_recv_rdy),
      .flush         (flush),
      .load_send_msg (load_send_msg),
      .load_send_val (load_send_val),
      .load_send_rdy (load_send_rdy),
      .partial       (partial),
      .count         (count)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   // Overflow / underflow watch
   always @(posedge clk) begin
      if (reset_n) begin
         if (word_recv_val && word_recv_rdy && partial && (count == CNT_W'(DEPTH))) begin
            miscompares++;
            $display("FAIL overflow: push with count %0d, max %0d", count, DEPTH);
         end
         if (load_send_rdy && load_send_val && (count == '0)) begin
            miscompares++;
            $display("FAIL underflow: pop with count %0d", count);
         end
      end
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   task automatic drive(input logic [31:0] w, input logic wv, input logic fl, input logic lr);
      @(negedge clk);
      word_recv_msg = w;
      word_recv_val = wv;
      flush         = fl;
      load_send_rdy = lr;
      #1;
   endtask

   initial begin
      // rdy, val, part, cnt, msg (msg only checked when val=1)
      vecs[0]  = '{32'h1111_1111, 1, 0, 1, 1, 0, 0, 2'd0, 64'h0};
      vecs[1]  = '{32'h2222_2222, 1, 0, 1, 1, 0, 1, 2'd0, 64'h0};
      vecs[2]  = '{32'h0,         0, 0, 1, 1, 1, 0, 2'd1, 64'h2222_2222_1111_1111};
      vecs[3]  = '{32'h0,         0, 0, 0, 1, 0, 0, 2'd0, 64'h0};
      vecs[4]  = '{32'h1000_0001, 1, 0, 0, 1, 0, 0, 2'd0, 64'h0};
      vecs[5]  = '{32'h1000_0002, 1, 0, 0, 1, 0, 1, 2'd0, 64'h0};
      vecs[6]  = '{32'h1000_0003, 1, 0, 0, 1, 1, 0, 2'd1, 64'h1000_0002_1000_0001};
      vecs[7]  = '{32'h1000_0004, 1, 0, 0, 1, 1, 1, 2'd1, 64'h1000_0002_1000_0001};
      vecs[8]  = '{32'h1000_0005, 1, 0, 0, 1, 1, 0, 2'd2, 64'h1000_0002_1000_0001};
      vecs[9]  = '{32'h1000_0006, 1, 0, 0, 0, 1, 1, 2'd2, 64'h1000_0002_1000_0001};
      vecs[10] = '{32'h1000_0006, 1, 0, 1, 0, 1, 1, 2'd2, 64'h1000_0002_1000_0001};
      vecs[11] = '{32'h1000_0006, 1, 0, 0, 1, 1, 1, 2'd1, 64'h1000_0004_1000_0003};
      vecs[12] = '{32'h0,         0, 0, 1, 1, 1, 0, 2'd2, 64'h1000_0004_1000_0003};
      vecs[13] = '{32'h0,         0, 0, 1, 1, 1, 0, 2'd1, 64'h1000_0006_1000_0005};
      vecs[14] = '{32'h0,         0, 0, 0, 1, 0, 0, 2'd0, 64'h0};
      vecs[15] = '{32'hAAAA_0000, 1, 0, 0, 1, 0, 0, 2'd0, 64'h0};
      vecs[16] = '{32'hDEAD_BEEF, 1, 1, 0, 0, 0, 1, 2'd0, 64'h0};
      vecs[17] = '{32'h0000_0001, 1, 0, 0, 1, 0, 0, 2'd0, 64'h0};
      vecs[18] = '{32'h0000_0002, 1, 0, 0, 1, 0, 1, 2'd0, 64'h0};
      vecs[19] = '{32'h0,         0, 0, 1, 1, 1, 0, 2'd1, 64'h0000_0002_0000_0001};
      vecs[20] = '{32'h0,         0, 0, 0, 1, 0, 0, 2'd0, 64'h0};

      // Reset and first post-reset cycles
      repeat (2) @(posedge clk);
      #1;
      check("reset_rdy", 64'(word_recv_rdy), 64'd0);
      check("reset_val", 64'(load_send_val), 64'd0);
      check("reset_cnt", 64'(count), 64'd0);
      check("reset_part", 64'(partial), 64'd0);
      @(negedge clk);
      reset_n = 1'b1;
      #1;
      check("first_cycle_rdy", 64'(word_recv_rdy), 64'd0);
      drive(32'h0, 0, 0, 0);
      check("second_cycle_rdy", 64'(word_recv_rdy), 64'd1);

      // Pack, fill/backpressure, flush
      for (int i = 0; i < int'(NV); i++) begin
         drive(vecs[i].w, vecs[i].wv, vecs[i].fl, vecs[i].lr);
         check($sformatf("v%0d_rdy", i), 64'(word_recv_rdy), 64'(vecs[i].e_rdy));
         check($sformatf("v%0d_val", i), 64'(load_send_val), 64'(vecs[i].e_val));
         check($sformatf("v%0d_part", i), 64'(partial), 64'(vecs[i].e_part));
         check($sformatf("v%0d_cnt", i), 64'(count), 64'(vecs[i].e_cnt));
         if (vecs[i].e_val) begin
            check($sformatf("v%0d_msg", i), load_send_msg, vecs[i].e_msg);
         end
      end

      // Steady state: push and pop together at count=1, pointers wrap
      drive(32'h5000_0000, 1, 0, 0);
      drive(32'h5000_0001, 1, 0, 0);
      q.push_back(64'h5000_0001_5000_0000);
      for (int i = 1; i <= 8; i++) begin
         drive(32'h5000_0000 + 32'(2 * i), 1, 0, 0);
         check($sformatf("ss%0d_cnt_lo", i), 64'(count), 64'd1);
         drive(32'h5000_0001 + 32'(2 * i), 1, 0, 1);
         check($sformatf("ss%0d_cnt_hi", i), 64'(count), 64'd1);
         check($sformatf("ss%0d_val", i), 64'(load_send_val), 64'd1);
         check($sformatf("ss%0d_msg", i), load_send_msg, q[0]);
         void'(q.pop_front());
         q.push_back({32'h5000_0001 + 32'(2 * i), 32'h5000_0000 + 32'(2 * i)});
      end
      drive(32'h0, 0, 0, 1);
      check("ss_drain_msg", load_send_msg, q[0]);
      void'(q.pop_front());
      drive(32'h0, 0, 0, 0);
      check("ss_drain_cnt", 64'(count), 64'd0);

      // Asynchronous reset with count=2, partial=1
      for (int i = 0; i < 5; i++) begin
         drive(32'h7000_0000 + 32'(i), 1, 0, 0);
      end
      drive(32'h0, 0, 0, 0);
      check("pre_rst_cnt", 64'(count), 64'd2);
      check("pre_rst_part", 64'(partial), 64'd1);
      #2;
      reset_n = 1'b0;
      #1;
      check("async_rst_val", 64'(load_send_val), 64'd0);
      check("async_rst_part", 64'(partial), 64'd0);
      check("async_rst_cnt", 64'(count), 64'd0);
      check("async_rst_rdy", 64'(word_recv_rdy), 64'd0);
      @(negedge clk);
      reset_n = 1'b1;
      drive(32'h0, 0, 0, 0);
      drive(32'hCAFE_0001, 1, 0, 0);
      check("post_rst_rdy", 64'(word_recv_rdy), 64'd1);
      drive(32'hCAFE_0002, 1, 0, 0);
      check("post_rst_part", 64'(partial), 64'd1);
      drive(32'h0, 0, 0, 1);
      check("post_rst_val", 64'(load_send_val), 64'd1);
      check("post_rst_msg", load_send_msg, 64'hCAFE_0002_CAFE_0001);
      drive(32'h0, 0, 0, 0);
      check("post_rst_cnt", 64'(count), 64'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
